// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic NOR-grid truth-table scanner.
// grid_out() is a behavioural reference for the grid, usable at any size up to 32x32.
package systolic_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StEmit
  } state_e;

  localparam int unsigned ROW_DEF    = 4;
  localparam int unsigned COLUMN_DEF = 10;
  localparam int unsigned IDX_W      = ROW_DEF + COLUMN_DEF;
  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  function automatic logic grid_out(input int unsigned rows, input int unsigned cols,
                                    input logic [31:0] in_row, input logic [31:0] in_col);
    logic [31:0] prev;
    logic [31:0] cur;
    logic        carry;
    prev = in_col;
    for (int unsigned i = 0; i < rows; i++) begin
      cur   = '0;
      carry = in_row[i];
      for (int unsigned j = 0; j < cols; j++) begin
        cur[j] = ~(carry | prev[j]);
        carry  = cur[j];
      end
      prev = cur;
    end
    return prev[cols-1];
  endfunction

endpackage

// File: rtl/systolic_tt_scan_if.sv
// Valid/ready stream carrying one truth-table bit and its input combination index.
interface systolic_tt_scan_if #(
  parameter int unsigned IdxW = systolic_pkg::IDX_W
) ();
  logic            tt_valid;
  logic            tt_ready;
  logic            tt_bit;
  logic [IdxW-1:0] tt_index;

  modport master (output tt_valid, output tt_bit, output tt_index, input tt_ready);
  modport slave  (input tt_valid, input tt_bit, input tt_index, output tt_ready);
endinterface

// File: rtl/systolic_row_eval.sv
// One row of the NOR grid: ripples the left boundary bit across COLUMN cells.
module systolic_row_eval #(
  parameter int unsigned COLUMN = 10
) (
  input  logic              left,
  input  logic [COLUMN-1:0] above,
  output logic [COLUMN-1:0] row
);

  always_comb begin
    logic w_carry;
    row     = '0;
    w_carry = left;
    for (int unsigned j = 0; j < COLUMN; j++) begin
      row[j]  = ~(w_carry | above[j]);
      w_carry = row[j];
    end
  end

endmodule

// File: rtl/systolic_tt_scan.sv
// Walks every (inRow, inColumn) combination, evaluates the NOR grid one row per cycle and
// streams each output bit. Define SYSTOLIC_TT_ONES_COUNT_EN to add the ones_count port.
module systolic_tt_scan
  import systolic_pkg::*;
#(
  parameter int unsigned ROW    = ROW_DEF,
  parameter int unsigned COLUMN = COLUMN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
  output logic [ROW+COLUMN:0] ones_count,
`endif
  systolic_tt_scan_if.master tt
);

  localparam int unsigned IdxW = ROW + COLUMN;
  localparam int unsigned CntW = $clog2(ROW + 1);

  state_e            r_state, w_state;
  logic [IdxW-1:0]   r_idx, w_idx, w_idx_inc;
  logic [COLUMN-1:0] r_row, w_row, w_eval_row;
  logic [CntW-1:0]   r_row_cnt, w_row_cnt;
  logic              r_bit, w_bit;
  logic              r_done, w_done;
  logic              w_left;

  assign w_idx_inc = r_idx + IdxW'(1);

  // Left boundary of the row being evaluated: inRow[row_cnt-1].
  always_comb begin
    w_left = 1'b0;
    for (int unsigned i = 0; i < ROW; i++) begin
      if (r_row_cnt == CntW'(i + 1)) w_left = r_idx[i];
    end
  end

  systolic_row_eval #(
    .COLUMN (COLUMN)
  ) u_row_eval (
    .left  (w_left),
    .above (r_row),
    .row   (w_eval_row)
  );

  always_comb begin
    w_state   = r_state;
    w_idx     = r_idx;
    w_row     = r_row;
    w_row_cnt = r_row_cnt;
    w_bit     = r_bit;
    w_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_idx     = '0;
          w_row     = '0;
          w_row_cnt = CntW'(1);
          w_state   = StEval;
        end
      end
      StEval: begin
        w_row = w_eval_row;
        if (r_row_cnt == CntW'(ROW)) begin
          w_bit   = w_eval_row[COLUMN-1];
          w_state = StEmit;
        end else begin
          w_row_cnt = r_row_cnt + CntW'(1);
        end
      end
      StEmit: begin
        if (tt.tt_ready) begin
          if (&r_idx) begin
            // Leave IDLE with every stream output low.
            w_idx     = '0;
            w_bit     = 1'b0;
            w_row     = '0;
            w_row_cnt = '0;
            w_done    = 1'b1;
            w_state   = StIdle;
          end else begin
            w_idx     = w_idx_inc;
            w_row     = w_idx_inc[IdxW-1:ROW];
            w_row_cnt = CntW'(1);
            w_state   = StEval;
          end
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_row     <= '0;
      r_row_cnt <= '0;
      r_bit     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_idx     <= w_idx;
      r_row     <= w_row;
      r_row_cnt <= w_row_cnt;
      r_bit     <= w_bit;
      r_done    <= w_done;
    end
  end

  assign busy        = (r_state != StIdle);
  assign done        = r_done;
  assign tt.tt_valid = (r_state == StEmit);
  assign tt.tt_bit   = r_bit;
  assign tt.tt_index = r_idx;

`ifdef SYSTOLIC_TT_ONES_COUNT_EN
  localparam int unsigned OnesW = IdxW + 1;
  logic [OnesW-1:0] r_ones;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ones <= '0;
    end else if ((r_state == StIdle) && start) begin
      r_ones <= '0;
    end else if ((r_state == StEmit) && tt.tt_ready && r_bit) begin
      r_ones <= r_ones + OnesW'(1);
    end
  end

  assign ones_count = r_ones;
`endif

endmodule

// File: tb/tb_systolic_tt_scan.sv
// Scoreboard bench: three scanner sizes (4x10 partial, 2x3 full, 1x1 full) checked against
// hand-computed bits and the grid_out reference.
module tb_systolic_tt_scan;
  import systolic_pkg::*;

  typedef struct {
    int unsigned idx;
    bit          b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_bc_n;
  logic start_a, start_b, start_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic bp_a, bp_b;
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
  logic [14:0] ones_a;
  logic [5:0]  ones_b;
  logic [2:0]  ones_c;
`endif

  systolic_tt_scan_if #(.IdxW(14)) if_a ();
  systolic_tt_scan_if #(.IdxW(5))  if_b ();
  systolic_tt_scan_if #(.IdxW(2))  if_c ();

  systolic_tt_scan #(.ROW(4), .COLUMN(10)) u_dut_a (
    .clk (clk), .rst_n (rst_a_n), .start (start_a), .busy (busy_a), .done (done_a),
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
    .ones_count (ones_a),
`endif
    .tt (if_a)
  );

  systolic_tt_scan #(.ROW(2), .COLUMN(3)) u_dut_b (
    .clk (clk), .rst_n (rst_bc_n), .start (start_b), .busy (busy_b), .done (done_b),
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
    .ones_count (ones_b),
`endif
    .tt (if_b)
  );

  systolic_tt_scan #(.ROW(1), .COLUMN(1)) u_dut_c (
    .clk (clk), .rst_n (rst_bc_n), .start (start_c), .busy (busy_c), .done (done_c),
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
    .ones_count (ones_c),
`endif
    .tt (if_c)
  );

  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: output presented with empty expectation queue (t=%0t)", name, $time);
  endtask

  function automatic bit ref_bit(input int unsigned rows, input int unsigned cols,
                                 input int unsigned idx);
    return grid_out(rows, cols, 32'(idx & ((32'd1 << rows) - 1)), 32'(idx >> rows));
  endfunction

  task automatic push_exp(input int d, input int unsigned idx, input bit b);
    exp_t e;
    e.idx = idx;
    e.b   = b;
    case (d)
      0: q_a.push_back(e);
      1: q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  function automatic int unsigned qsize(input int d);
    case (d)
      0: return q_a.size();
      1: return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  function automatic logic get_done(input int d);
    case (d)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic get_busy(input int d);
    case (d)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

`ifdef SYSTOLIC_TT_ONES_COUNT_EN
  function automatic int unsigned get_ones(input int d);
    case (d)
      0: return 32'(ones_a);
      1: return 32'(ones_b);
      default: return 32'(ones_c);
    endcase
  endfunction
`endif

  task automatic set_start(input int d, input logic v);
    case (d)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic wait_q(input int d, input int unsigned lim, input int unsigned bound,
                        input string name);
    int unsigned n = 0;
    while (qsize(d) > lim && n < bound) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(qsize(d) <= lim), 1);
  endtask

  // Pulses start, then counts edges after the accepting edge until done is seen.
  task automatic run_scan(input int d, input int unsigned exp_cyc, input int unsigned exp_ones,
                          input string name);
    int unsigned cnt = 0;
    int unsigned busy_low = 0;
    @(posedge clk); #1;
    set_start(d, 1'b1);
    @(posedge clk); #1;
    set_start(d, 1'b0);
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
    check({name, "_ones_clear"}, get_ones(d), 0);
`endif
    while (!get_done(d) && cnt < 20000) begin
      if (!get_busy(d)) busy_low++;
      @(posedge clk); #1;
      cnt++;
    end
    check({name, "_done_seen"}, 32'(get_done(d)), 1);
    if (exp_cyc != 0) check({name, "_cycles"}, cnt, exp_cyc);
    check({name, "_busy_low_during_scan"}, busy_low, 0);
    check({name, "_busy_at_done"}, 32'(get_busy(d)), 0);
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
    check({name, "_ones_count"}, get_ones(d), exp_ones);
`else
    if (exp_ones > 32'd1_000_000) check({name, "_ones_bound"}, exp_ones, 0);
`endif
    @(posedge clk); #1;
    check({name, "_done_single_pulse"}, 32'(get_done(d)), 0);
  endtask

  // Ready drivers: backpressure holds ready low about 30 % of cycles.
  initial begin
    if_a.tt_ready = 1'b1;
    if_b.tt_ready = 1'b1;
    if_c.tt_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if_a.tt_ready = bp_a ? ($urandom_range(0, 9) >= 3) : 1'b1;
      if_b.tt_ready = bp_b ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end

  // Monitors: pop and compare on every handshake; stalled outputs must hold.
  logic        a_stall = 1'b0, b_stall = 1'b0;
  int unsigned a_hold_idx, b_hold_idx;
  logic        a_hold_bit, b_hold_bit;

  always @(negedge clk) begin
    exp_t e;
    if (a_stall && if_a.tt_valid) begin
      check("a_stall_idx_hold", 32'(if_a.tt_index), a_hold_idx);
      check("a_stall_bit_hold", 32'(if_a.tt_bit), 32'(a_hold_bit));
    end
    a_stall    = if_a.tt_valid && !if_a.tt_ready;
    a_hold_idx = 32'(if_a.tt_index);
    a_hold_bit = if_a.tt_bit;
    if (if_a.tt_valid && if_a.tt_ready) begin
      if (q_a.size() == 0) fail("a_unexpected");
      else begin
        e = q_a.pop_front();
        check("a_idx", 32'(if_a.tt_index), e.idx);
        check("a_bit", 32'(if_a.tt_bit), 32'(e.b));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_stall && if_b.tt_valid) begin
      check("b_stall_idx_hold", 32'(if_b.tt_index), b_hold_idx);
      check("b_stall_bit_hold", 32'(if_b.tt_bit), 32'(b_hold_bit));
    end
    b_stall    = if_b.tt_valid && !if_b.tt_ready;
    b_hold_idx = 32'(if_b.tt_index);
    b_hold_bit = if_b.tt_bit;
    if (if_b.tt_valid && if_b.tt_ready) begin
      if (q_b.size() == 0) fail("b_unexpected");
      else begin
        e = q_b.pop_front();
        check("b_idx", 32'(if_b.tt_index), e.idx);
        check("b_bit", 32'(if_b.tt_bit), 32'(e.b));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_c.tt_valid && if_c.tt_ready) begin
      if (q_c.size() == 0) fail("c_unexpected");
      else begin
        e = q_c.pop_front();
        check("c_idx", 32'(if_c.tt_index), e.idx);
        check("c_bit", 32'(if_c.tt_bit), 32'(e.b));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    int unsigned ones_b_exp;
    rst_a_n  = 1'b0;
    rst_bc_n = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    bp_a     = 1'b0;
    bp_b     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_a_n  = 1'b1;
    rst_bc_n = 1'b1;
    @(negedge clk);
    check("rst_a_busy", 32'(busy_a), 0);
    check("rst_a_done", 32'(done_a), 0);
    check("rst_a_valid", 32'(if_a.tt_valid), 0);
    check("rst_a_index", 32'(if_a.tt_index), 0);
    check("rst_a_bit", 32'(if_a.tt_bit), 0);
    check("rst_b_valid", 32'(if_b.tt_valid), 0);
    check("rst_c_busy", 32'(busy_c), 0);
`ifdef SYSTOLIC_TT_ONES_COUNT_EN
    check("rst_a_ones", 32'(ones_a), 0);
`endif

    // 4x10: idx 0 -> 1 and idx 15 -> 0 worked by hand.
    for (int unsigned i = 0; i < 60; i++) begin
      if (i == 0) push_exp(0, i, 1'b1);
      else if (i == 15) push_exp(0, i, 1'b0);
      else push_exp(0, i, ref_bit(4, 10, i));
    end
    @(posedge clk); #1;
    start_a = 1'b1;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 1) begin
        start_a = 1'b0;
        check("a_busy_after_start", 32'(busy_a), 1);
      end
    end while (!if_a.tt_valid && cnt < 50);
    check("a_first_valid_latency", cnt, 5);

    wait_q(0, 50, 200, "a_progress_1");
    // start held across EVAL and EMIT must be ignored.
    repeat (7) begin
      @(posedge clk); #1;
      start_a = 1'b1;
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_q(0, 45, 400, "a_progress_2");
    bp_a = 1'b1;
    wait_q(0, 5, 3000, "a_progress_backpressure");
    bp_a = 1'b0;

    @(posedge clk); #1;
    rst_a_n = 1'b0;
    @(posedge clk); #1;
    check("a_midrst_busy", 32'(busy_a), 0);
    check("a_midrst_done", 32'(done_a), 0);
    check("a_midrst_valid", 32'(if_a.tt_valid), 0);
    check("a_midrst_index", 32'(if_a.tt_index), 0);
    check("a_midrst_bit", 32'(if_a.tt_bit), 0);
    q_a.delete();
    rst_a_n = 1'b1;
    for (int unsigned i = 0; i < 10; i++) push_exp(0, i, (i == 0) ? 1'b1 : ref_bit(4, 10, i));
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_q(0, 5, 400, "a_restart_progress");
    @(posedge clk); #1;
    rst_a_n = 1'b0;
    @(posedge clk); #1;
    q_a.delete();
    rst_a_n = 1'b1;

    // 2x3 full scan: 32 vectors x 3 cycles.
    ones_b_exp = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      push_exp(1, i, ref_bit(2, 3, i));
      ones_b_exp += 32'(ref_bit(2, 3, i));
    end
    run_scan(1, 96, ones_b_exp, "b_scan");
    check("b_drained", q_b.size(), 0);

    for (int unsigned i = 0; i < 32; i++) push_exp(1, i, ref_bit(2, 3, i));
    bp_b = 1'b1;
    run_scan(1, 0, ones_b_exp, "b_bp_scan");
    bp_b = 1'b0;
    check("b_bp_drained", q_b.size(), 0);

    // 1x1: out = ~(inRow | inColumn).
    push_exp(2, 0, 1'b1);
    push_exp(2, 1, 1'b0);
    push_exp(2, 2, 1'b0);
    push_exp(2, 3, 1'b0);
    run_scan(2, 8, 1, "c_scan");
    check("c_drained", q_c.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/systolic_tt_scan.md
# systolic_tt_scan

Sequential truth-table generator for the ROW×COLUMN systolic NOR grid. On `start` it walks every input combination (inRow, inColumn) in index order. For each combination it evaluates the grid one row per cycle and streams the resulting output bit over a valid/ready interface. It drives the other end of the grid's interface: it produces the stimulus and collects the response. The result feeds gate-level cross-checking and truth-table export for the DNACompiler netlists.

## Interface
Parameters:
- `ROW`, 4, grid rows; width of inRow; ≥1.
- `COLUMN`, 10, grid columns; width of inColumn; ≥1.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: begin a scan; sampled only in IDLE.
- `busy` output 1: high from the cycle after `start` is accepted until the last bit is accepted.
- `done` output 1: one-cycle pulse after the last handshake.
- `tt_valid` output 1: output bit valid.
- `tt_ready` input 1: consumer ready.
- `tt_bit` output 1: grid output w[ROW][COLUMN] for `tt_index`.
- `tt_index` output ROW+COLUMN: current combination; inRow = tt_index[ROW-1:0], inColumn = tt_index[ROW+COLUMN-1:ROW].
- `ones_count` output ROW+COLUMN+1: present only with the configuration macro (see Configuration).

## Operation
- Grid function:
  - Boundary: w[i][0] = inRow[i-1] and w[0][j] = inColumn[j-1].
  - Cell: w[i][j] = ~(w[i][j-1] | w[i-1][j]).
  - Output: out = w[ROW][COLUMN].
- State: `row_q[COLUMN-1:0]` holds the previous grid row; `row_cnt` counts 1..ROW; `idx` is ROW+COLUMN bits.
- FSM states are IDLE, EVAL and EMIT.
  - IDLE: outputs low. When `start`=1: idx←0, row_q←inColumn(idx=0), row_cnt←1, go to EVAL.
  - EVAL: each cycle row_q←rowfunc(inRow[row_cnt-1], row_q), where rowfunc is a ripple across j. When row_cnt==ROW, go to EMIT with tt_bit←new row_q[COLUMN-1]; otherwise row_cnt++.
  - EMIT: `tt_valid`=1. `tt_bit` and `tt_index` are held stable until `tt_valid & tt_ready`.
    - On handshake, if idx is all ones: go to IDLE, pulse `done`, `busy`←0.
    - On handshake otherwise: idx++, row_q←inColumn(idx+1), row_cnt←1, go to EVAL.
- `start` while not in IDLE is ignored.
- No wrap-around: idx never increments past the all-ones value.
- `tt_ready` has no effect outside EMIT.
- Reset in any state:
  - Returns the FSM to IDLE and clears idx, row_cnt and row_q.
  - Clears `busy`, `done`, `tt_valid`, `tt_bit` and `tt_index` to 0, and `ones_count` to 0.
  - Any in-flight bit is discarded.

## Timing
- `start` accepted at edge N: `busy`=1 and EVAL from N+1.
- First `tt_valid` appears at N+ROW+1.
- Each vector costs ROW EVAL cycles plus at least 1 EMIT cycle.
- With `tt_ready` held at 1, a full scan takes 2^(ROW+COLUMN)·(ROW+1) cycles, i.e. 81920 cycles at the defaults.
- `done` is asserted in the cycle after the final handshake, together with `busy`=0.
- A new `start` is accepted in that same cycle, or any later cycle.
- Backpressure stalls only EMIT. There is no bubble beyond what `tt_ready` causes.

## Configuration
- `SYSTOLIC_TT_ONES_COUNT_EN` defined:
  - Adds the `ones_count` port and its register.
  - The register clears on `start` acceptance and increments on every handshake with `tt_bit`=1.
  - Its value is final and stable from the `done` cycle until the next `start`.
- Macro not defined: the port and the counter are absent; all other behaviour is identical.

## Structure
- `systolic_pkg` holds:
  - the FSM state enum (IDLE/EVAL/EMIT);
  - localparams `IDX_W = ROW+COLUMN` and `LAST_IDX`;
  - a reference function `grid_out(inRow, inColumn)`, shared with the bench.
- Sub-module `systolic_row_eval`: purely combinational.
  - Inputs: `left` (1 bit) and `above[COLUMN-1:0]`.
  - Output: `row[COLUMN-1:0]` implementing the ripple NOR row.
  - The top block instantiates it once.

## Test plan
- Reset, then `start` with `tt_ready`=1:
  - idx 0 gives `tt_bit`=1.
  - idx 15 (inRow=4'hF, inColumn=0) gives `tt_bit`=0.
  - idx 16383 gives `tt_bit`=1.
  - First `tt_valid` appears exactly 5 cycles after `start`.
- Full scan compared against `grid_out`:
  - all 16384 bits match;
  - `done` pulses once at cycle 81920 after `start`;
  - `busy` is high throughout.
- Random `tt_ready` backpressure (≈30 % low):
  - `tt_bit` and `tt_index` stay stable while stalled;
  - no index is skipped or duplicated.
- `start` pulsed during EVAL and EMIT is ignored; `rst_n`=0 mid-scan:
  - next cycle all outputs are 0 and the state is IDLE;
  - a new `start` restarts from idx 0.
- With `SYSTOLIC_TT_ONES_COUNT_EN`:
  - `ones_count` at `done` equals the reference count from `grid_out`;
  - `ones_count` clears on the next `start`.
- ROW=1, COLUMN=1 build: bits for idx 0..3 are 1,0,0,0, and `done` occurs after 8 cycles.
